spi_accel_responder: RTL and testbench

SPI mode-0 slave that emulates the ADXL362-style accelerometer on the board's SPI bus, for closed-loop checking of the SPI master chain (control FSM, shift handler, VGA data path) without the physical sensor. It oversamples SCLK_A/SS/MOSI on the system clock, decodes 0x0A write / 0x0B read transactions with auto-incrementing address, serves ID, sample and status registers on MISO, and raises INT1 when a new sample is loaded. It sits on the PMOD side of the bus, or in the testbench, facing the master's SCLK_A/SS/MOSI/MISO.

---
 rtl/spi_accel_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_accel_responder.sv
// -----------------------------------------------------------------------------
// spi_accel_responder
//   SPI mode-0 slave that stands in for an ADXL362-style accelerometer so the
//   SPI master chain can be exercised closed-loop without the real sensor.
//   All SPI pins are oversampled on CLK. Command 0x0A writes and command 0x0B
//   reads; both take an address byte and then auto-increment through a burst.
//
// Ports
//   CLK         system clock, at least 8x SCLK_A
//   ARST_L      asynchronous active-low reset
//   SCLK_A      SPI clock from master (idles low, asynchronous to CLK)
//   SS          slave select, active-low
//   MOSI        master-out data, sampled on SCLK_A rise
//   MISO        slave-out data, MSB first, updated on SCLK_A fall
//   XDATA_IN,
//   YDATA_IN,
//   ZDATA_IN    emulated sample bytes
//   SAMPLE_STB  one-CLK pulse: new sample present on *_IN
//   INT1        data-ready interrupt, active-high level
// -----------------------------------------------------------------------------
module spi_accel_responder #(
   parameter logic [7:0] DEVID_AD  = 8'hAD,
   parameter logic [7:0] DEVID_MST = 8'h1D,
   parameter logic [7:0] PARTID    = 8'hF2
) (
   input  logic       CLK,
   input  logic       ARST_L,
   input  logic       SCLK_A,
   input  logic       SS,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [7:0] XDATA_IN,
   input  logic [7:0] YDATA_IN,
   input  logic [7:0] ZDATA_IN,
   input  logic       SAMPLE_STB,
   output logic       INT1
);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WDATA,
      RDATA,
      IGNORE
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;
   localparam logic [7:0] ADDR_X    = 8'h08;

   // ---------------------------------------------------------------------------
   // Synchronizers and registered edge detection
   // ---------------------------------------------------------------------------
   logic [1:0] sclk_sync, ss_sync, mosi_sync;
   logic       sclk_d, ss_d, mosi_d;
   logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic       ss_s;

   assign ss_s = ss_sync[1];

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         // SS idles high, so its pipeline resets to the idle level and no
         // spurious edge is seen when reset releases.
         sclk_sync <= 2'b00;
         ss_sync   <= 2'b11;
         mosi_sync <= 2'b00;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
         mosi_d    <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         ss_rise   <= 1'b0;
         ss_fall   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge
         // value, so the chain advances exactly one stage per clock.
         sclk_sync <= {sclk_sync[0], SCLK_A};
         ss_sync   <= {ss_sync[0], SS};
         mosi_sync <= {mosi_sync[0], MOSI};
         sclk_d    <= sclk_sync[1];
         ss_d      <= ss_sync[1];
         // mosi_d lines up with the registered sclk_rise pulse.
         mosi_d    <= mosi_sync[1];
         sclk_rise <= sclk_sync[1] & ~sclk_d;
         sclk_fall <= ~sclk_sync[1] & sclk_d;
         ss_rise   <= ss_sync[1] & ~ss_d;
         ss_fall   <= ~ss_sync[1] & ss_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Transaction state
   // ---------------------------------------------------------------------------
   state_t      state, state_n;
   logic [2:0]  bit_cnt;
   logic [7:0]  rx_shreg, tx_shreg, addr;
   logic [7:0]  rx_byte, next_addr, load_addr, rd_data;
   logic        is_read, byte_done, tx_load, wr_en;
   logic [7:0]  wr_regs [16];

   logic [7:0]  x_reg, y_reg, z_reg;
   logic [7:0]  x_pend, y_pend, z_pend;
   logic        pend, data_ready;
   logic        apply_now, apply_pend;

   assign rx_byte   = {rx_shreg[6:0], mosi_d};
   assign byte_done = sclk_rise && (bit_cnt == 3'd7);
   assign next_addr = addr + 8'd1;
   // The byte just received is the start address in ADDR; otherwise the
   // burst moves to the following address (wrapping at 0xFF).
   assign load_addr = (state == ADDR) ? rx_byte : next_addr;

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_n = state;
      tx_load = 1'b0;
      wr_en   = 1'b0;
      case (state)
         IDLE:   if (ss_fall) state_n = CMD;
         CMD:    if (byte_done)
                    state_n = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ADDR : IGNORE;
         ADDR:   if (byte_done) begin
                    state_n = is_read ? RDATA : WDATA;
                    tx_load = is_read;
                 end
         WDATA:  if (byte_done) wr_en = (addr[7:4] == 4'h2);
         RDATA:  if (byte_done) tx_load = 1'b1;
         IGNORE: state_n = IGNORE;
         default: state_n = IDLE;
      endcase
      // Deselect ends the transaction from any state; a partial byte is lost.
      if (ss_rise) begin
         state_n = IDLE;
         tx_load = 1'b0;
         wr_en   = 1'b0;
      end
   end

   // Register read map, indexed by the address about to be loaded.
   always_comb begin
      rd_data = 8'h00;
      case (load_addr)
         8'h00:   rd_data = DEVID_AD;
         8'h01:   rd_data = DEVID_MST;
         8'h02:   rd_data = PARTID;
         8'h08:   rd_data = x_reg;
         8'h09:   rd_data = y_reg;
         8'h0A:   rd_data = z_reg;
         8'h0B:   rd_data = {7'b0, data_ready};
         default: if (load_addr[7:4] == 4'h2) rd_data = wr_regs[load_addr[3:0]];
      endcase
   end

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         bit_cnt  <= 3'd0;
         rx_shreg <= 8'h00;
         tx_shreg <= 8'h00;
         addr     <= 8'h00;
         is_read  <= 1'b0;
         MISO     <= 1'b0;
         // NOTE: this 16-byte file is small and must read back 0x00 after
         // reset, so it is built from resettable flops rather than a RAM.
         for (int i = 0; i < 16; i++) wr_regs[i] <= 8'h00;
      end else begin
         if (state == IDLE && ss_fall) begin
            bit_cnt  <= 3'd0;
            rx_shreg <= 8'h00;
         end else if (state != IDLE && sclk_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shreg <= rx_byte;
         end

         if (state == CMD && byte_done) is_read <= (rx_byte == CMD_READ);

         if (state == ADDR && byte_done)
            addr <= rx_byte;
         else if ((state == WDATA || state == RDATA) && byte_done)
            addr <= next_addr;

         if (wr_en) wr_regs[addr[3:0]] <= rx_byte;

         if (tx_load)
            tx_shreg <= rd_data;
         else if (state == RDATA && sclk_fall)
            tx_shreg <= {tx_shreg[6:0], 1'b0};

         if (ss_s || state != RDATA)
            MISO <= 1'b0;
         else if (sclk_fall)
            MISO <= tx_shreg[7];
      end
   end

   // ---------------------------------------------------------------------------
   // Sample holding registers and data-ready flag
   //   A strobe while deselected loads at once; one during a transaction is
   //   parked and applied once synced SS is high again, so a burst never sees
   //   the sample bytes change under it.
   // ---------------------------------------------------------------------------
   assign apply_now  = SAMPLE_STB & ss_s;
   assign apply_pend = pend & ss_s & ~SAMPLE_STB;

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         x_reg      <= 8'h00;
         y_reg      <= 8'h00;
         z_reg      <= 8'h00;
         x_pend     <= 8'h00;
         y_pend     <= 8'h00;
         z_pend     <= 8'h00;
         pend       <= 1'b0;
         data_ready <= 1'b0;
      end else begin
         if (apply_now) begin
            x_reg <= XDATA_IN;
            y_reg <= YDATA_IN;
            z_reg <= ZDATA_IN;
            pend  <= 1'b0;
         end else if (SAMPLE_STB) begin
            x_pend <= XDATA_IN;
            y_pend <= YDATA_IN;
            z_pend <= ZDATA_IN;
            pend   <= 1'b1;
         end else if (apply_pend) begin
            x_reg <= x_pend;
            y_reg <= y_pend;
            z_reg <= z_pend;
            pend  <= 1'b0;
         end

         // A new sample outranks the read-of-X clear in the same cycle.
         if (apply_now || apply_pend)
            data_ready <= 1'b1;
         else if (tx_load && load_addr == ADDR_X)
            data_ready <= 1'b0;
      end
   end

   assign INT1 = data_ready;

endmodule

// File: tb/tb_spi_accel_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_accel_responder
//   Drives spi_accel_responder as a mode-0 SPI master. A transaction-level
//   model of the register map predicts each MISO byte and the INT1 level;
//   predictions go into exp_q, observations into got_q, and a monitor process
//   pairs them up in order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_accel_responder;

   logic       CLK = 1'b0;
   logic       ARST_L;
   logic       SCLK_A;
   logic       SS;
   logic       MOSI;
   logic       MISO;
   logic [7:0] XDATA_IN, YDATA_IN, ZDATA_IN;
   logic       SAMPLE_STB;
   logic       INT1;

   spi_accel_responder dut (
      .CLK        (CLK),
      .ARST_L     (ARST_L),
      .SCLK_A     (SCLK_A),
      .SS         (SS),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .XDATA_IN   (XDATA_IN),
      .YDATA_IN   (YDATA_IN),
      .ZDATA_IN   (ZDATA_IN),
      .SAMPLE_STB (SAMPLE_STB),
      .INT1       (INT1)
   );

   always #5 CLK = ~CLK;

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   typedef struct {
      string      name;
      logic [7:0] val;
   } obs_t;

   obs_t       got_q[$];
   logic [7:0] exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
      end
   endtask

   initial begin : monitor
      obs_t       o;
      logic [7:0] e;
      forever begin
         @(negedge CLK);
         while (got_q.size() > 0 && exp_q.size() > 0) begin
            o = got_q.pop_front();
            e = exp_q.pop_front();
            check(o.name, o.val, e);
         end
      end
   end

   function automatic void push_exp(input logic [7:0] v);
      exp_q.push_back(v);
   endfunction

   function automatic void push_got(input string n, input logic [7:0] v);
      obs_t o;
      o.name = n;
      o.val  = v;
      got_q.push_back(o);
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model: register contents and interrupt level
   // ---------------------------------------------------------------------------
   logic [7:0] m_wr [16];
   logic [7:0] m_x, m_y, m_z, m_px, m_py, m_pz;
   logic       m_dr, m_pend, m_in_xfer;

   function automatic void m_reset();
      for (int i = 0; i < 16; i++) m_wr[i] = 8'h00;
      m_x = 8'h00; m_y = 8'h00; m_z = 8'h00;
      m_px = 8'h00; m_py = 8'h00; m_pz = 8'h00;
      m_dr = 1'b0; m_pend = 1'b0;
   endfunction

   function automatic logic [7:0] m_reg(input logic [7:0] a);
      if (a == 8'h00) return 8'hAD;
      if (a == 8'h01) return 8'h1D;
      if (a == 8'h02) return 8'hF2;
      if (a == 8'h08) return m_x;
      if (a == 8'h09) return m_y;
      if (a == 8'h0A) return m_z;
      if (a == 8'h0B) return {7'b0, m_dr};
      if (a >= 8'h20 && a <= 8'h2F) return m_wr[int'(a) - 32];
      return 8'h00;
   endfunction

   // Fetching a byte for transmission; fetching X acknowledges the sample.
   function automatic logic [7:0] m_fetch(input logic [7:0] a);
      logic [7:0] v;
      v = m_reg(a);
      if (a == 8'h08) m_dr = 1'b0;
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [7:0] bq[$];
   int         xfer_id = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int b = 0; b < nbits; b++) begin
         MOSI = tx[3'(7 - b)];
         tick(8);
         rx = {rx[6:0], MISO};
         SCLK_A = 1'b1;
         tick(8);
         SCLK_A = 1'b0;
      end
   endtask

   task automatic strobe(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] sz);
      XDATA_IN = sx; YDATA_IN = sy; ZDATA_IN = sz;
      SAMPLE_STB = 1'b1;
      tick(1);
      SAMPLE_STB = 1'b0;
      if (m_in_xfer) begin
         m_pend = 1'b1;
         m_px = sx; m_py = sy; m_pz = sz;
      end else begin
         m_x = sx; m_y = sy; m_z = sz;
         m_dr = 1'b1;
         push_exp({7'b0, m_dr});
         push_got("int1 one clk after strobe", {7'b0, INT1});
      end
   endtask

   // Runs bq as one SS-low transaction, optionally with a strobe before byte
   // stb_at and a trailing partial byte before deselect.
   task automatic run_xfer(input int part_bits, input logic [7:0] part_val, input int stb_at,
                           input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] sz);
      logic [7:0] cmd, addr, tx_m, rx, b;
      cmd = 8'h00; addr = 8'h00; tx_m = 8'h00;
      xfer_id++;
      SS = 1'b0;
      m_in_xfer = 1'b1;
      tick(8);
      for (int i = 0; i < bq.size(); i++) begin
         if (i == stb_at) strobe(sx, sy, sz);
         b = bq[i];
         push_exp((i >= 2 && cmd == 8'h0B) ? tx_m : 8'h00);
         spi_bits(b, 8, rx);
         push_got($sformatf("xfer %0d miso byte %0d", xfer_id, i), rx);
         if (i == 0) begin
            cmd = b;
         end else if (cmd == 8'h0A || cmd == 8'h0B) begin
            if (i == 1) begin
               addr = b;
               if (cmd == 8'h0B) tx_m = m_fetch(addr);
            end else if (cmd == 8'h0A) begin
               if (addr >= 8'h20 && addr <= 8'h2F) m_wr[int'(addr) - 32] = b;
               addr = addr + 8'd1;
            end else begin
               addr = addr + 8'd1;
               tx_m = m_fetch(addr);
            end
         end
         push_exp({7'b0, m_dr});
         push_got($sformatf("xfer %0d int1 after byte %0d", xfer_id, i), {7'b0, INT1});
      end
      if (part_bits > 0) spi_bits(part_val, part_bits, rx);
      tick(4);
      SS = 1'b1;
      m_in_xfer = 1'b0;
      if (m_pend) begin
         m_x = m_px; m_y = m_py; m_z = m_pz;
         m_dr = 1'b1;
         m_pend = 1'b0;
      end
      tick(12);
      push_exp({7'b0, m_dr});
      push_got($sformatf("xfer %0d int1 after deselect", xfer_id), {7'b0, INT1});
      push_exp(8'h00);
      push_got($sformatf("xfer %0d miso idle", xfer_id), {7'b0, MISO});
   endtask

   // Directed transaction: n bytes packed MSB-first into p.
   task automatic xfer(input logic [63:0] p, input int n);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(p[8 * (n - 1 - i) +: 8]);
      run_xfer(0, 8'h00, -1, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation still running at 2 ms, expected to finish earlier");
      $fatal(1, "timeout");
   end

   logic [7:0] addr_pool [12] = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h08, 8'h09,
                                  8'h0A, 8'h0B, 8'h1E, 8'h2E, 8'h2F, 8'hFE};

   initial begin : stimulus
      logic [7:0] rx, tmp, cmd, a;
      int         r, nd, pb, sa;

      ARST_L = 1'b0; SS = 1'b1; SCLK_A = 1'b0; MOSI = 1'b0;
      SAMPLE_STB = 1'b0; XDATA_IN = 8'h00; YDATA_IN = 8'h00; ZDATA_IN = 8'h00;
      m_in_xfer = 1'b0;
      m_reset();
      tick(3);
      push_exp(8'h00); push_got("miso in reset", {7'b0, MISO});
      push_exp(8'h00); push_got("int1 in reset", {7'b0, INT1});
      ARST_L = 1'b1;
      tick(5);
      push_exp(8'h00); push_got("miso after reset", {7'b0, MISO});
      push_exp(8'h00); push_got("int1 after reset", {7'b0, INT1});

      // ID burst
      xfer(64'h0B_00_00_00_00, 5);
      // Sample, interrupt, read X/Y/Z, then STATUS
      strobe(8'h12, 8'h34, 8'h56);
      xfer(64'h0B_08_00_00_00, 5);
      xfer(64'h0B_0B_00, 3);
      // Write past the writable window, then read back
      xfer(64'h0A_2E_A5_5A_77, 5);
      xfer(64'h0B_2E_00_00_00, 5);
      // Aborted write: partial byte must not commit
      bq.delete(); bq.push_back(8'h0A); bq.push_back(8'h20);
      run_xfer(5, 8'hFF, -1, 8'h00, 8'h00, 8'h00);
      xfer(64'h0B_20_00, 3);
      // Strobe during a read of X: old value served, new one applied on deselect
      bq.delete(); bq.push_back(8'h0B); bq.push_back(8'h08);
      bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'h00);
      run_xfer(0, 8'h00, 3, 8'h99, 8'h99, 8'h99);
      xfer(64'h0B_08_00_00_00, 5);
      // Unknown command, then confirm registers untouched
      xfer(64'h0C_2E_11, 3);
      xfer(64'h0B_2E_00_00, 4);
      // Address wrap during bursts
      xfer(64'h0A_FF_11_22, 4);
      xfer(64'h0B_FE_00_00_00_00_00, 7);

      // Reset in the middle of a read with INT1 set and MISO high
      strobe(8'h01, 8'h02, 8'h03);
      SS = 1'b0;
      m_in_xfer = 1'b1;
      tick(8);
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h00, 8, rx);
      tick(6);
      tmp = m_reg(8'h00);
      push_exp({7'b0, tmp[7]}); push_got("miso before mid-read reset", {7'b0, MISO});
      push_exp({7'b0, m_dr});   push_got("int1 before mid-read reset", {7'b0, INT1});
      ARST_L = 1'b0;
      #1;
      m_reset();
      push_exp(8'h00); push_got("miso during mid-read reset", {7'b0, MISO});
      push_exp(8'h00); push_got("int1 during mid-read reset", {7'b0, INT1});
      SS = 1'b1;
      m_in_xfer = 1'b0;
      tick(3);
      ARST_L = 1'b1;
      tick(4);
      xfer(64'h0B_08_00_00_00, 5);
      xfer(64'h0B_2E_00, 3);

      // Randomized transactions
      for (int t = 0; t < 30; t++) begin
         r   = $urandom_range(0, 3);
         cmd = (r == 0) ? 8'h0A : (r < 3) ? 8'h0B : 8'($urandom);
         a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 11)];
         nd  = $urandom_range(0, 4);
         bq.delete();
         bq.push_back(cmd);
         bq.push_back(a);
         for (int k = 0; k < nd; k++) bq.push_back(8'($urandom));
         pb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
         sa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, bq.size() - 1)) : -1;
         run_xfer(pb, 8'($urandom), sa, 8'($urandom), 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 3) == 0) strobe(8'($urandom), 8'($urandom), 8'($urandom));
      end

      // Final sweep of the writable window
      for (int s = 0; s < 3; s++) begin
         bq.delete();
         bq.push_back(8'h0B);
         bq.push_back(8'(8'h20 + 6 * s));
         for (int k = 0; k < 6; k++) bq.push_back(8'h00);
         run_xfer(0, 8'h00, -1, 8'h00, 8'h00, 8'h00);
      end

      tick(10);
      n_tests++;
      if (got_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: %0d observations and %0d expectations left, expected 0 and 0",
                  got_q.size(), exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
